// File: rtl/eco32_core_ifu_icm_alloc.sv
// Writer side of the IFU 16-entry I-cache miss table: slot allocation, table write, line-fill request, slot free.
// Optional occupancy statistics (occ / occ_max) are enabled by defining ECO32_ICM_ALLOC_STATS_EN.
module eco32_core_ifu_icm_alloc #(
    parameter int PTR_W  = 4,
    parameter int REQ_TO = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             miss_stb,
    output logic             miss_ack,
    input  logic [25:0]      miss_v_addr,
    input  logic [3:0]       miss_asid,
    input  logic             miss_wid,
    input  logic             miss_tid,
    output logic             wr_stb,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [25:0]      wr_v_addr,
    output logic [3:0]       wr_asid,
    output logic             wr_wid,
    output logic             wr_tag,
    output logic             wr_tid,
    output logic             mem_req,
    output logic [PTR_W-1:0] mem_ptr,
    input  logic             mem_ack,
    output logic             mem_tout,
    input  logic             fill_stb,
    input  logic [PTR_W-1:0] fill_ptr,
    output logic             fill_err,
    input  logic             flush_stb,
    output logic             flush_ack,
`ifdef ECO32_ICM_ALLOC_STATS_EN
    output logic [PTR_W:0]   occ,
    output logic [PTR_W:0]   occ_max,
`endif
    output logic             full
);

    localparam int DEPTH = 1 << PTR_W;
    localparam int CNT_W = $clog2(REQ_TO + 2);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(REQ_TO);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(REQ_TO + 1);
    localparam bit TOUT_EN = (REQ_TO != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_REQ   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [25:0]        vaddr_q, vaddr_d;
    logic [3:0]         asid_q, asid_d;
    logic               wid_q, wid_d;
    logic               tid_q, tid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               full_q, full_d;
    logic               flush_ack_q, flush_ack_d;
    logic               fill_err_q, fill_err_d;
    logic [PTR_W-1:0]   free_ptr;

    // Lowest-index free slot; descending scan so the smallest index wins.
    always_comb begin
        free_ptr = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_ptr = PTR_W'(i);
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d     = state_q;
        valid_d     = valid_q;
        ptr_d       = ptr_q;
        vaddr_d     = vaddr_q;
        asid_d      = asid_q;
        wid_d       = wid_q;
        tid_d       = tid_q;
        cnt_d       = '0;
        flush_ack_d = 1'b0;
        fill_err_d  = 1'b0;
        miss_ack    = 1'b0;
        wr_stb      = 1'b0;
        mem_req     = 1'b0;

        if (fill_stb) begin
            if (valid_q[fill_ptr]) begin
                valid_d[fill_ptr] = 1'b0;
            end else begin
                fill_err_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (flush_stb) begin
                    valid_d     = '0;
                    flush_ack_d = 1'b1;
                end else if (miss_stb && !full_q) begin
                    // Allocation looks at the pre-free bitmap; a slot freed this cycle is usable next cycle.
                    miss_ack          = 1'b1;
                    ptr_d             = free_ptr;
                    vaddr_d           = miss_v_addr;
                    asid_d            = miss_asid;
                    wid_d             = miss_wid;
                    tid_d             = miss_tid;
                    valid_d[free_ptr] = 1'b1;
                    state_d           = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wr_stb  = 1'b1;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        full_d = &valid_d;
    end

    // NOTE: the valid bitmap is a handful of flops, not a RAM, so it is reset along with the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            valid_q     <= '0;
            ptr_q       <= '0;
            vaddr_q     <= '0;
            asid_q      <= '0;
            wid_q       <= 1'b0;
            tid_q       <= 1'b0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            flush_ack_q <= 1'b0;
            fill_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q     <= state_d;
            valid_q     <= valid_d;
            ptr_q       <= ptr_d;
            vaddr_q     <= vaddr_d;
            asid_q      <= asid_d;
            wid_q       <= wid_d;
            tid_q       <= tid_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            flush_ack_q <= flush_ack_d;
            fill_err_q  <= fill_err_d;
        end
    end

    // The counter saturates one past REQ_TO, so the pulse fires once per request.
    assign mem_tout  = TOUT_EN && (state_q == ST_REQ) && (cnt_q == TO_VAL);
    assign wr_ptr    = ptr_q;
    assign wr_v_addr = vaddr_q;
    assign wr_asid   = asid_q;
    assign wr_wid    = wid_q;
    assign wr_tid    = tid_q;
    assign wr_tag    = wr_stb;
    assign mem_ptr   = ptr_q;
    assign full      = full_q;
    assign fill_err  = fill_err_q;
    assign flush_ack = flush_ack_q;

`ifdef ECO32_ICM_ALLOC_STATS_EN
    logic [PTR_W:0] occ_q, occ_d;
    logic [PTR_W:0] occ_max_q, occ_max_d;

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + (PTR_W + 1)'(valid_d[i]);
        end
        if (state_q == ST_IDLE && flush_stb) begin
            occ_max_d = '0;
        end else begin
            occ_max_d = (occ_d > occ_max_q) ? occ_d : occ_max_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q     <= '0;
            occ_max_q <= '0;
        end else begin
            occ_q     <= occ_d;
            occ_max_q <= occ_max_d;
        end
    end

    assign occ     = occ_q;
    assign occ_max = occ_max_q;
`endif

endmodule

// File: tb/tb_eco32_core_ifu_icm_alloc.sv
// Self-checking bench for eco32_core_ifu_icm_alloc: directed scenarios plus randomized miss/fill traffic
// checked against a slot-array reference model.
module tb_eco32_core_ifu_icm_alloc;

    localparam int PTR_W  = 4;
    localparam int DEPTH  = 16;
    localparam int REQ_TO = 255;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             miss_stb;
    logic             miss_ack;
    logic [25:0]      miss_v_addr;
    logic [3:0]       miss_asid;
    logic             miss_wid;
    logic             miss_tid;
    logic             wr_stb;
    logic [PTR_W-1:0] wr_ptr;
    logic [25:0]      wr_v_addr;
    logic [3:0]       wr_asid;
    logic             wr_wid;
    logic             wr_tag;
    logic             wr_tid;
    logic             mem_req;
    logic [PTR_W-1:0] mem_ptr;
    logic             mem_ack;
    logic             mem_tout;
    logic             fill_stb;
    logic [PTR_W-1:0] fill_ptr;
    logic             fill_err;
    logic             flush_stb;
    logic             flush_ack;
    logic             full;
`ifdef ECO32_ICM_ALLOC_STATS_EN
    logic [PTR_W:0]   occ;
    logic [PTR_W:0]   occ_max;
`endif

    eco32_core_ifu_icm_alloc #(.PTR_W(PTR_W), .REQ_TO(REQ_TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_stb(miss_stb), .miss_ack(miss_ack), .miss_v_addr(miss_v_addr),
        .miss_asid(miss_asid), .miss_wid(miss_wid), .miss_tid(miss_tid),
        .wr_stb(wr_stb), .wr_ptr(wr_ptr), .wr_v_addr(wr_v_addr), .wr_asid(wr_asid),
        .wr_wid(wr_wid), .wr_tag(wr_tag), .wr_tid(wr_tid),
        .mem_req(mem_req), .mem_ptr(mem_ptr), .mem_ack(mem_ack), .mem_tout(mem_tout),
        .fill_stb(fill_stb), .fill_ptr(fill_ptr), .fill_err(fill_err),
        .flush_stb(flush_stb), .flush_ack(flush_ack),
`ifdef ECO32_ICM_ALLOC_STATS_EN
        .occ(occ), .occ_max(occ_max),
`endif
        .full(full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    bit mv[DEPTH];   // reference model: slot occupied

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < DEPTH; i++) if (!mv[i]) return i;
        return -1;
    endfunction

    function automatic int count_valid();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(mv[i]);
        return c;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full miss transaction; optionally a fill on the same cycle as the miss request.
    task automatic do_miss(input logic [25:0] va, input logic [3:0] asid, input logic wid,
                           input logic tid, input int lat, input bit do_fill, input int fptr);
        int  exp_ptr;
        bit  exp_err;
        int  tcnt;
        int  tat;
        exp_ptr     = lowest_free();
        miss_stb    = 1'b1;
        miss_v_addr = va;
        miss_asid   = asid;
        miss_wid    = wid;
        miss_tid    = tid;
        if (do_fill) begin
            fill_stb = 1'b1;
            fill_ptr = PTR_W'(fptr);
        end
        #1;
        check("miss_ack", miss_ack, 1);
        exp_err = do_fill && !mv[fptr];
        mv[exp_ptr] = 1'b1;
        if (do_fill && !exp_err) mv[fptr] = 1'b0;
        step();
        miss_stb    = 1'b0;
        fill_stb    = 1'b0;
        miss_v_addr = ~va;
        miss_asid   = ~asid;
        miss_wid    = ~wid;
        miss_tid    = ~tid;
        #1;
        check("wr_stb", wr_stb, 1);
        check("wr_ptr", wr_ptr, exp_ptr);
        check("wr_tag", wr_tag, 1);
        check("wr_v_addr", wr_v_addr, va);
        check("wr_asid", wr_asid, asid);
        check("wr_wid", wr_wid, wid);
        check("wr_tid", wr_tid, tid);
        check("mem_req_in_write", mem_req, 0);
        check("fill_err", fill_err, exp_err);
        check("full", full, count_valid() == DEPTH);
`ifdef ECO32_ICM_ALLOC_STATS_EN
        check("occ", occ, count_valid());
`endif
        step();
        check("wr_stb_drop", wr_stb, 0);
        check("mem_req", mem_req, 1);
        check("mem_ptr", mem_ptr, exp_ptr);
        tcnt = 0;
        tat  = -1;
        for (int off = 0; off <= lat; off++) begin
            if (mem_tout === 1'b1) begin
                tcnt++;
                tat = off;
            end
            if (off == lat) begin
                check("mem_req_held", mem_req, 1);
                mem_ack = 1'b1;
            end
            step();
        end
        mem_ack = 1'b0;
        check("mem_req_done", mem_req, 0);
        check("mem_tout_count", tcnt, (lat >= REQ_TO) ? 1 : 0);
        if (lat >= REQ_TO) check("mem_tout_offset", tat, REQ_TO);
    endtask

    initial begin
        int  fp;
        bit  err;
        rst_n       = 1'b0;
        miss_stb    = 1'b0;
        miss_v_addr = '0;
        miss_asid   = '0;
        miss_wid    = 1'b0;
        miss_tid    = 1'b0;
        mem_ack     = 1'b0;
        fill_stb    = 1'b0;
        fill_ptr    = '0;
        flush_stb   = 1'b0;
        clear_model();

        // Reset state
        #2;
        check("rst_miss_ack", miss_ack, 0);
        check("rst_wr_stb", wr_stb, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_tout", mem_tout, 0);
        check("rst_fill_err", fill_err, 0);
        check("rst_flush_ack", flush_ack, 0);
        check("rst_full", full, 0);
        check("rst_wr_ptr", wr_ptr, 0);
`ifdef ECO32_ICM_ALLOC_STATS_EN
        check("rst_occ", occ, 0);
        check("rst_occ_max", occ_max, 0);
`endif
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single miss, then fill the table completely
        do_miss(26'h0ABCDE, 4'h3, 1'b1, 1'b0, 0, 1'b0, 0);
        for (int i = 1; i < DEPTH; i++) begin
            do_miss(26'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), i % 3, 1'b0, 0);
        end
        check("full_after_16", full, 1);
`ifdef ECO32_ICM_ALLOC_STATS_EN
        check("occ_max_16", occ_max, 16);
`endif

        // 17th miss stalls while full; a fill of slot 5 lets it through
        miss_stb    = 1'b1;
        miss_v_addr = 26'h1234567 & 26'h3FFFFFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_miss_ack", miss_ack, 0);
            step();
            check("stall_wr_stb", wr_stb, 0);
        end
        fill_stb = 1'b1;
        fill_ptr = 4'd5;
        #1;
        check("stall_ack_fill_cycle", miss_ack, 0);
        step();
        fill_stb = 1'b0;
        mv[5]    = 1'b0;
        check("full_after_fill", full, 0);
        check("fill_err_valid", fill_err, 0);
        do_miss(26'h2000005, 4'h5, 1'b0, 1'b1, 1, 1'b0, 0);

        // mem_ack outside REQ is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("idle_mem_ack_req", mem_req, 0);
        check("idle_mem_ack_wr", wr_stb, 0);

        // Free slot 0, allocate it, then flush while in REQ
        fill_stb = 1'b1;
        fill_ptr = 4'd0;
        step();
        fill_stb = 1'b0;
        mv[0]    = 1'b0;
        miss_stb    = 1'b1;
        miss_v_addr = 26'h0000F00;
        #1;
        check("flush_miss_ack", miss_ack, 1);
        mv[0] = 1'b1;
        step();
        miss_stb = 1'b0;
        check("flush_wr_ptr", wr_ptr, 0);
        step();
        flush_stb = 1'b1;
        miss_stb  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("flush_wait_ack", flush_ack, 0);
            check("flush_wait_miss", miss_ack, 0);
            check("flush_wait_req", mem_req, 1);
            step();
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        #1;
        check("flush_idle_ack", flush_ack, 0);
        check("flush_prio_miss", miss_ack, 0);
        step();
        flush_stb = 1'b0;
        clear_model();
        check("flush_ack", flush_ack, 1);
        check("flush_full", full, 0);
`ifdef ECO32_ICM_ALLOC_STATS_EN
        check("flush_occ_max", occ_max, 0);
`endif
        do_miss(26'h0ABCDE, 4'h1, 1'b0, 1'b0, 0, 1'b0, 0);
        check("flush_ack_pulse", flush_ack, 0);

        // Fill of invalid slot 3
        fill_stb = 1'b1;
        fill_ptr = 4'd3;
        step();
        fill_stb = 1'b0;
        check("fill_err_pulse", fill_err, 1);
        step();
        check("fill_err_clear", fill_err, 0);
        do_miss(26'h0000123, 4'h2, 1'b1, 1'b1, 0, 1'b0, 0);

        // Timeout: ack held off for 300 cycles
        do_miss(26'h3FFFFFF, 4'hF, 1'b1, 1'b1, 300, 1'b0, 0);

        // Randomized miss/fill traffic
        for (int it = 0; it < 200; it++) begin
            if (count_valid() == DEPTH || $urandom_range(3, 0) == 0) begin
                fp       = int'($urandom_range(DEPTH - 1, 0));
                err      = !mv[fp];
                fill_stb = 1'b1;
                fill_ptr = PTR_W'(fp);
                step();
                fill_stb = 1'b0;
                if (!err) mv[fp] = 1'b0;
                check("rnd_fill_err", fill_err, err);
                check("rnd_full", full, count_valid() == DEPTH);
            end else begin
                do_miss(26'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                        int'($urandom_range(3, 0)), ($urandom_range(2, 0) == 0),
                        int'($urandom_range(DEPTH - 1, 0)));
            end
        end

        // Reset while mem_req is high
        flush_stb = 1'b1;
        step();
        flush_stb = 1'b0;
        clear_model();
        step();
        miss_stb = 1'b1;
        #1;
        step();
        miss_stb = 1'b0;
        step();
        check("pre_rst_mem_req", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_mem_req", mem_req, 0);
        check("midrst_wr_stb", wr_stb, 0);
        check("midrst_full", full, 0);
        check("midrst_mem_ptr", mem_ptr, 0);
`ifdef ECO32_ICM_ALLOC_STATS_EN
        check("midrst_occ", occ, 0);
        check("midrst_occ_max", occ_max, 0);
`endif
        step();
        rst_n = 1'b1;
        step();
        do_miss(26'h0011223, 4'h7, 1'b0, 1'b1, 0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
